// File: rtl/data_ram_pipe_if.sv
// Load/store bus between the LSU (master) and the pipelined data RAM (slave).
// The debug mirror of the low RAM words travels with the bus.
interface data_ram_pipe_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DBG_WORDS  = 8
);
  localparam int unsigned NB = DATA_WIDTH / 8;

  logic                            req;
  logic                            we;
  logic [ADDR_WIDTH-1:0]           addr;
  logic [NB-1:0]                   byte_sel;
  logic [DATA_WIDTH-1:0]           sdata;
  logic                            par_inj;
  logic                            ready;
  logic                            rvalid;
  logic [DATA_WIDTH-1:0]           ldata;
  logic                            addr_err;
  logic                            perr;
  logic [DBG_WORDS*DATA_WIDTH-1:0] dbg_ram;

  modport master (
    output req, we, addr, byte_sel, sdata, par_inj,
    input  ready, rvalid, ldata, addr_err, perr, dbg_ram
  );

  modport slave (
    input  req, we, addr, byte_sel, sdata, par_inj,
    output ready, rvalid, ldata, addr_err, perr, dbg_ram
  );
endinterface

// File: rtl/data_ram_pipe.sv
// Single-port data SRAM for the MEM stage: synchronous read through an
// RD_LAT-deep pipe, REQ/READY accept, post-reset clear sweep, misalignment
// flagging and a combinational mirror of the low words for debug.
// Optional per-byte even parity is enabled by defining DATA_RAM_PARITY_EN.
// Assumes DATA_WIDTH >= 16 and ADDR_WIDTH > log2(DEPTH) + log2(DATA_WIDTH/8).
module data_ram_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned DBG_WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  data_ram_pipe_if.slave    bus
);
  localparam int unsigned NB  = DATA_WIDTH / 8;
  localparam int unsigned OFF = $clog2(NB);
  localparam int unsigned IDX = $clog2(DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic [IDX-1:0]        cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic [RD_LAT-1:0]     vld_q, vld_d;
  logic [RD_LAT-1:0]     err_q, err_d;
  logic [RD_LAT-1:0]     perr_q, perr_d;
  logic [DATA_WIDTH-1:0] dat_q [RD_LAT];
  logic [DATA_WIDTH-1:0] dat_d [RD_LAT];

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  wr_en;
  logic [IDX-1:0]        wr_idx;
  logic [NB-1:0]         wr_lanes;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_par_inj;

  logic                  acc;
  logic                  acc_mis;
  logic [IDX-1:0]        acc_idx;
  logic                  rd_perr_c;
  logic                  unused_addr_c;

  // Request decode: word index, alignment and accept qualifier
  assign acc_idx       = bus.addr[IDX+OFF-1:OFF];
  assign acc_mis       = |bus.addr[OFF-1:0];
  assign acc           = bus.req & ready_q;
  assign unused_addr_c = ^bus.addr[ADDR_WIDTH-1:IDX+OFF];

`ifdef DATA_RAM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];

  // Parity check of the word addressed by the current request
  always_comb begin
    rd_perr_c = 1'b0;
    for (int i = 0; i < int'(NB); i++) begin
      if ((^mem_q[acc_idx][i*8 +: 8]) != par_q[acc_idx][i]) rd_perr_c = 1'b1;
    end
  end

  // Parity storage: even parity per written lane, optionally inverted
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (wr_lanes[i]) par_q[wr_idx][i] <= (^wr_data[i*8 +: 8]) ^ wr_par_inj;
      end
    end
  end
`else
  logic unused_par_c;

  assign rd_perr_c    = 1'b0;
  assign unused_par_c = bus.par_inj ^ wr_par_inj;
`endif

  // Next state: clear sweep, accept decode, write port and read pipe advance
  always_comb begin
    logic st_err;
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_en      = 1'b0;
    wr_idx     = cnt_q;
    wr_lanes   = '0;
    wr_data    = '0;
    wr_par_inj = 1'b0;
    st_err     = 1'b0;
    vld_d[0]   = 1'b0;
    err_d[0]   = 1'b0;
    perr_d[0]  = 1'b0;
    dat_d[0]   = '0;
    for (int k = 1; k < int'(RD_LAT); k++) begin
      vld_d[k]  = vld_q[k-1];
      err_d[k]  = err_q[k-1];
      perr_d[k] = perr_q[k-1];
      dat_d[k]  = dat_q[k-1];
    end

    case (state_q)
      ST_INIT: begin
        wr_en    = 1'b1;
        wr_idx   = cnt_q;
        wr_lanes = '1;
        cnt_d    = cnt_q + IDX'(1);
        if (cnt_q == IDX'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (acc) begin
          if (bus.we) begin
            if (acc_mis) begin
              st_err = 1'b1;
            end else begin
              wr_en      = 1'b1;
              wr_idx     = acc_idx;
              wr_lanes   = bus.byte_sel;
              wr_data    = bus.sdata;
              wr_par_inj = bus.par_inj;
            end
          end else begin
            vld_d[0]  = 1'b1;
            err_d[0]  = acc_mis;
            perr_d[0] = ~acc_mis & rd_perr_c;
            dat_d[0]  = acc_mis ? '0 : mem_q[acc_idx];
          end
        end
      end
      default: state_d = ST_INIT;
    endcase

    // A misaligned store flags on the cycle straight after its accept edge
    err_d[RD_LAT-1] = err_d[RD_LAT-1] | st_err;
    ready_d         = (state_d == ST_RUN);
  end

  // Control and read-pipe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      vld_q   <= '0;
      err_q   <= '0;
      perr_q  <= '0;
      for (int k = 0; k < int'(RD_LAT); k++) dat_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      perr_q  <= perr_d;
      for (int k = 0; k < int'(RD_LAT); k++) dat_q[k] <= dat_d[k];
    end
  end

  // Data array: byte-lane writes
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (wr_lanes[i]) mem_q[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  assign bus.ready    = ready_q;
  assign bus.rvalid   = vld_q[RD_LAT-1];
  assign bus.ldata    = dat_q[RD_LAT-1];
  assign bus.addr_err = err_q[RD_LAT-1];
  assign bus.perr     = perr_q[RD_LAT-1];

  // Debug mirror of the low words
  for (genvar k = 0; k < int'(DBG_WORDS); k++) begin : g_dbg
    assign bus.dbg_ram[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k];
  end
endmodule

// File: tb/tb_data_ram_pipe.sv
// Directed bench for data_ram_pipe: sweep timing, byte-lane stores, latency,
// ordering, aliasing, misalignment, reset with loads in flight, parity.
module tb_data_ram_pipe;
  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 32;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned RD_LAT = 3;
  localparam int unsigned DBGW   = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  data_ram_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DBG_WORDS(DBGW)) bus ();

  data_ram_pipe #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .DBG_WORDS(DBGW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req      = 1'b0;
    bus.we       = 1'b0;
    bus.addr     = '0;
    bus.byte_sel = '0;
    bus.sdata    = '0;
    bus.par_inj  = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] sel, input logic inj);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = a;
    bus.byte_sel = sel; bus.sdata = d; bus.par_inj = inj;
    tick();
    idle();
  endtask

  // Load with latency check: nothing before RD_LAT, one-cycle pulse after
  task automatic do_load(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                         input logic exp_err, input logic exp_perr);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = a;
    tick();
    idle();
    chk({tag, " early_rvalid"}, 32'(bus.rvalid), 32'd0);
    for (int k = 1; k < int'(RD_LAT); k++) tick();
    chk({tag, " rvalid"}, 32'(bus.rvalid), 32'd1);
    chk({tag, " ldata"}, bus.ldata, exp_d);
    chk({tag, " addr_err"}, 32'(bus.addr_err), 32'(exp_err));
    chk({tag, " perr"}, 32'(bus.perr), 32'(exp_perr));
    tick();
    chk({tag, " rvalid_end"}, 32'(bus.rvalid), 32'd0);
    chk({tag, " ldata_end"}, bus.ldata, 32'd0);
  endtask

  // Counts cycles from reset release until READY rises; no RVALID may appear
  task automatic wait_ready(input string tag);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    chk({tag, " ready_at_release"}, 32'(bus.ready), 32'd0);
    while (bus.ready !== 1'b1 && n < int'(4 * DEPTH)) begin
      tick();
      n++;
      if (bus.rvalid === 1'b1) seen = 1'b1;
    end
    chk({tag, " sweep_cycles"}, 32'(n), 32'(DEPTH));
    chk({tag, " no_rvalid"}, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] exp3 [3];
    logic        seen;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle();

    #3;
    chk("rst ready", 32'(bus.ready), 32'd0);
    chk("rst rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst ldata", bus.ldata, 32'd0);
    chk("rst addr_err", 32'(bus.addr_err), 32'd0);
    chk("rst perr", 32'(bus.perr), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready("init");

    do_load("clr0", 32'h0, 32'h0, 1'b0, 1'b0);
    do_load("clr_top", 32'((DEPTH - 1) * 4), 32'h0, 1'b0, 1'b0);

    do_store(32'h10, 32'hDEADBEEF, 4'b1111, 1'b0);
    chk("dbg word4", bus.dbg_ram[4*DW +: DW], 32'hDEADBEEF);
    do_store(32'h10, 32'h000000AA, 4'b0001, 1'b0);
    do_load("lane", 32'h10, 32'hDEADBEAA, 1'b0, 1'b0);
    do_load("alias", 32'h10 + 32'(DEPTH * 4), 32'hDEADBEAA, 1'b0, 1'b0);

    do_store(32'h4, 32'h11112222, 4'b1111, 1'b0);
    do_load("st_ld", 32'h4, 32'h11112222, 1'b0, 1'b0);

    do_store(32'h0, 32'h33334444, 4'b1111, 1'b0);
    do_store(32'h8, 32'h55556666, 4'b1111, 1'b0);
    exp3[0] = 32'h33334444;
    exp3[1] = 32'h11112222;
    exp3[2] = 32'h55556666;
    for (int c = 0; c < 6; c++) begin
      int j;
      if (c < 3) begin
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'(c * 4);
      end else begin
        idle();
      end
      tick();
      j = c - int'(RD_LAT - 1);
      if (j >= 0 && j < 3) begin
        chk($sformatf("b2b rvalid%0d", j), 32'(bus.rvalid), 32'd1);
        chk($sformatf("b2b ldata%0d", j), bus.ldata, exp3[j]);
      end else begin
        chk($sformatf("b2b idle%0d", c), 32'(bus.rvalid), 32'd0);
      end
    end

    do_store(32'h6, 32'hFFFFFFFF, 4'b1111, 1'b0);
    chk("mis_st addr_err", 32'(bus.addr_err), 32'd1);
    chk("mis_st no_rvalid", 32'(bus.rvalid), 32'd0);
    tick();
    chk("mis_st addr_err_end", 32'(bus.addr_err), 32'd0);
    chk("mis_st dbg word1", bus.dbg_ram[1*DW +: DW], 32'h11112222);
    do_load("mis_st word1", 32'h4, 32'h11112222, 1'b0, 1'b0);
    do_load("mis_ld", 32'h3, 32'h0, 1'b1, 1'b0);

    do_store(32'h20, 32'h12345678, 4'b1111, 1'b1);
`ifdef DATA_RAM_PARITY_EN
    do_load("par_inj", 32'h20, 32'h12345678, 1'b0, 1'b1);
    do_store(32'h20, 32'h12345678, 4'b1111, 1'b0);
    do_load("par_clean", 32'h20, 32'h12345678, 1'b0, 1'b0);
`else
    do_load("par_off", 32'h20, 32'h12345678, 1'b0, 1'b0);
`endif

    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h4;
    tick();
    bus.addr = 32'h8;
    tick();
    idle();
    rst_n = 1'b0;
    seen = 1'b0;
    #1;
    if (bus.rvalid === 1'b1) seen = 1'b1;
    for (int k = 0; k < int'(RD_LAT) + 1; k++) begin
      tick();
      if (bus.rvalid === 1'b1) seen = 1'b1;
    end
    chk("flight no_rvalid", 32'(seen), 32'd0);
    chk("flight ready", 32'(bus.ready), 32'd0);
    rst_n = 1'b1;
    wait_ready("resweep");
    do_load("resweep word1", 32'h4, 32'h0, 1'b0, 1'b0);
    do_load("resweep word4", 32'h10, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
